// File: rtl/booth4_seq_signed_divider.sv
// booth4_seq_signed_divider: sequential signed restoring divider, one quotient bit per clock.
// Works on magnitudes throughout; signs and the divide-by-zero / overflow rules are applied in FIX.
module booth4_seq_signed_divider #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [D-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state;
    logic [W-1:0]  dm;
    logic [D-1:0]  vm;
    logic [D-1:0]  pr;
    logic          sd, sq, dbz, ovf;
    logic [CW-1:0] cnt;
    logic [D:0]    sh, trial;

    // dm shifts out dividend bits at the top and collects quotient bits at the bottom
    always_comb begin
        sh    = {pr, dm[W-1]};
        trial = sh - {1'b0, vm};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            cnt         <= '0;
            dm          <= '0;
            vm          <= '0;
            pr          <= '0;
            sd          <= 1'b0;
            sq          <= 1'b0;
            dbz         <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dm    <= dividend[W-1] ? -dividend : dividend;
                        vm    <= divisor[D-1] ? -divisor : divisor;
                        sd    <= dividend[W-1];
                        sq    <= dividend[W-1] ^ divisor[D-1];
                        dbz   <= divisor == '0;
                        ovf   <= dividend == MOST_NEG && divisor == '1;
                        pr    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    pr  <= trial[D] ? sh[D-1:0] : trial[D-1:0];
                    dm  <= {dm[W-2:0], ~trial[D]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    quotient    <= dbz ? '0 : ovf ? MOST_NEG : sq ? -dm : dm;
                    remainder   <= (dbz || ovf) ? '0 : sd ? -pr : pr;
                    div_by_zero <= dbz;
                    overflow    <= ovf && !dbz;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth4_seq_signed_divider.sv
// tb_booth4_seq_signed_divider: random and directed stimulus checked every cycle against an
// integer-arithmetic reference of the divider's timing and results.
module tb_booth4_seq_signed_divider;
    localparam int W = 8;
    localparam int D = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [D-1:0] r;
        logic         z;
        logic         o;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [D-1:0] divisor = '0;
    logic         busy, done, div_by_zero, overflow;
    logic [W-1:0] quotient;
    logic [D-1:0] remainder;

    int errors = 0;
    int checks = 0;

    booth4_seq_signed_divider #(.W(W), .D(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic res_t ref_div(input logic [W-1:0] a, input logic [D-1:0] b);
        res_t res;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        res = '{q: '0, r: '0, z: 1'b0, o: 1'b0};
        if (sb == 0) res.z = 1'b1;
        else if (sa == -(1 <<< (W - 1)) && sb == -1) begin
            res.q = {1'b1, {(W-1){1'b0}}};
            res.o = 1'b1;
        end else begin
            res.q = W'(sa / sb);
            res.r = D'(sa % sb);
        end
        return res;
    endfunction

    // Reference timing: a start seen in an idle cycle at edge n0 gives busy after edges
    // n0..n0+W and done after edge n0+W+1; the next start is accepted from edge n0+W+2.
    logic         s_start;
    logic [W-1:0] s_a;
    logic [D-1:0] s_b;
    int   n = 0, n0 = 0, free_at = 0;
    bit   active = 0;
    res_t pend, shown;

    initial shown = '{q: '0, r: '0, z: 1'b0, o: 1'b0};

    always @(posedge clk) begin
        s_start <= start;
        s_a     <= dividend;
        s_b     <= divisor;
    end

    always @(negedge clk) begin
        n++;
        if (!rst_n) begin
            active  = 0;
            free_at = 0;
            shown   = '{q: '0, r: '0, z: 1'b0, o: 1'b0};
        end else if (s_start && n >= free_at) begin
            n0      = n;
            free_at = n + W + 2;
            active  = 1;
            pend    = ref_div(s_a, s_b);
        end
        if (active && n == n0 + W + 1) shown = pend;
        chk("busy", 32'(busy), 32'(active && n <= n0 + W));
        chk("done", 32'(done), 32'(active && n == n0 + W + 1));
        chk("quotient", 32'(quotient), 32'(shown.q));
        chk("remainder", 32'(remainder), 32'(shown.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(shown.z));
        chk("overflow", 32'(overflow), 32'(shown.o));
    end

    task automatic op_start(input logic [W-1:0] a, input logic [D-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts edges from the start edge (inclusive) to the edge that raises done
    task automatic op_wait(output int lat, output int bc);
        int k = 0;
        bc = 0;
        while (!done && k < 3 * W) begin
            if (busy) bc++;
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
        lat = k + 1;
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] q, input logic [D-1:0] r,
                              input logic z, input logic o);
        chk({nm, "_q"}, 32'(quotient), 32'(q));
        chk({nm, "_r"}, 32'(remainder), 32'(r));
        chk({nm, "_dbz"}, 32'(div_by_zero), 32'(z));
        chk({nm, "_ovf"}, 32'(overflow), 32'(o));
    endtask

    initial begin
        int lat, bc;
        repeat (2) @(negedge clk);
        expect_out("reset", 8'h00, 4'h0, 1'b0, 1'b0);
        chk("reset_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        op_start(8'd100, 4'd7);
        op_wait(lat, bc);
        chk("lat_100_7", 32'(lat), 32'(W + 2));
        chk("busy_cycles", 32'(bc), 32'(W + 1));
        expect_out("100_7", 8'h0E, 4'h2, 1'b0, 1'b0);
        op_start(8'h9C, 4'd7);
        op_wait(lat, bc);
        expect_out("m100_7", 8'hF2, 4'hE, 1'b0, 1'b0);
        op_start(8'd100, 4'h8);
        op_wait(lat, bc);
        expect_out("100_m8", 8'hF4, 4'h4, 1'b0, 1'b0);
        op_start(8'h80, 4'hF);
        op_wait(lat, bc);
        expect_out("ovf", 8'h80, 4'h0, 1'b0, 1'b1);
        op_start(8'd55, 4'h0);
        op_wait(lat, bc);
        chk("lat_dbz", 32'(lat), 32'(W + 2));
        expect_out("dbz", 8'h00, 4'h0, 1'b1, 1'b0);

        @(negedge clk);
        op_start(8'd100, 4'd7);
        repeat (2) @(negedge clk);
        op_start(8'd1, 4'd1);
        op_wait(lat, bc);
        expect_out("ignored_start", 8'h0E, 4'h2, 1'b0, 1'b0);
        op_start(8'd20, 4'hD);
        op_wait(lat, bc);
        chk("lat_back_to_back", 32'(lat), 32'(W + 2));
        expect_out("20_m3", 8'hFA, 4'h2, 1'b0, 1'b0);

        op_start(8'd50, 4'd3);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        expect_out("async_rst", 8'h00, 4'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        op_start(8'd127, 4'd3);
        op_wait(lat, bc);
        expect_out("127_3", 8'h2A, 4'h1, 1'b0, 1'b0);

        for (int a = 0; a < (1 << W); a++)
            for (int b = 0; b < (1 << D); b++) begin
                op_start(W'(a), D'(b));
                op_wait(lat, bc);
            end

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            dividend = W'($urandom);
            divisor  = D'($urandom);
        end
        start = 1'b0;
        repeat (2 * W) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
